// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Port 0 is the integer issue path, port 1 the address/branch-compare helper.
//   Round-robin arbitration, one registered result buffer per port, 1-cycle latency.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   per-port request handshake (req_ready = grant)
//   req_a, req_b          per-port operands, port i in [i*XLEN +: XLEN]
//   req_op                4-bit ALU select per port, port i in [i*4 +: 4]
//   req_word              per-port word-op flag (sign-extend result from bit 31)
//   rsp_valid/rsp_ready   per-port result handshake
//   rsp_data              per-port registered result
//   busy                  any request pending or any result buffer full
module alu_arbiter #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned FAIR_RESET_PRI = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*XLEN-1:0] req_a,
   input  logic [2*XLEN-1:0] req_b,
   input  logic [7:0]        req_op,
   input  logic [1:0]        req_word,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [2*XLEN-1:0] rsp_data,
   output logic              busy
);

   localparam int unsigned ShW      = $clog2(XLEN);
   localparam logic        ResetPri = (FAIR_RESET_PRI != 0);

   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpAnd  = 4'd2,
      OpOr   = 4'd3,
      OpXor  = 4'd4,
      OpSlt  = 4'd5,
      OpSltu = 4'd6,
      OpSll  = 4'd7,
      OpSrl  = 4'd8,
      OpSra  = 4'd9
   } alu_op_e;

   logic [1:0]            rsp_valid_q, rsp_valid_d;
   logic [1:0][XLEN-1:0]  rsp_data_q, rsp_data_d;
   logic                  pri_q, pri_d;

   logic [1:0]            can_accept;
   logic [1:0]            eligible;
   logic [1:0]            grant;

   logic [XLEN-1:0]       alu_a, alu_b, alu_raw, alu_y;
   logic [3:0]            alu_op;
   logic                  alu_word;
   logic [ShW-1:0]        shamt;

   // Arbitration depends only on handshake state, never on operands.
   always_comb begin
      can_accept = ~rsp_valid_q | rsp_ready;
      eligible   = req_valid & can_accept;
      grant      = eligible;
      if (eligible == 2'b11) begin
         grant = pri_q ? 2'b10 : 2'b01;
      end
   end

   // Operand mux; defaults to port 0 when nothing is granted (result unused).
   always_comb begin
      alu_a    = req_a[0 +: XLEN];
      alu_b    = req_b[0 +: XLEN];
      alu_op   = req_op[0 +: 4];
      alu_word = req_word[0];
      if (grant[1]) begin
         alu_a    = req_a[XLEN +: XLEN];
         alu_b    = req_b[XLEN +: XLEN];
         alu_op   = req_op[4 +: 4];
         alu_word = req_word[1];
      end
   end

   // Shared ALU. Shifts use only the low log2(XLEN) bits of b.
   always_comb begin
      shamt   = alu_b[ShW-1:0];
      alu_raw = '0;
      case (alu_op)
         OpAdd:   alu_raw = alu_a + alu_b;
         OpSub:   alu_raw = alu_a - alu_b;
         OpAnd:   alu_raw = alu_a & alu_b;
         OpOr:    alu_raw = alu_a | alu_b;
         OpXor:   alu_raw = alu_a ^ alu_b;
         OpSlt:   alu_raw = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         OpSltu:  alu_raw = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
         OpSll:   alu_raw = alu_a << shamt;
         OpSrl:   alu_raw = alu_a >> shamt;
         OpSra:   alu_raw = XLEN'($signed(alu_a) >>> shamt);
         default: alu_raw = '0;
      endcase
   end

   // Word ops sign-extend from bit 31; a no-op when XLEN is 32.
   always_comb begin
      alu_y = alu_raw;
      if (alu_word) begin
         for (int i = 32; i < int'(XLEN); i++) begin
            alu_y[i] = alu_raw[31];
         end
      end
   end

   // A grant both refills and keeps the buffer valid, so a drain in the
   // same cycle never creates a bubble.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      for (int i = 0; i < 2; i++) begin
         if (grant[i]) begin
            rsp_valid_d[i] = 1'b1;
            rsp_data_d[i]  = alu_y;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
      // Pointer only moves on contention, to the port that lost.
      pri_d = (eligible == 2'b11) ? ~pri_q : pri_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         pri_q       <= ResetPri;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         pri_q       <= pri_d;
      end
   end

   assign req_ready = grant;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (|req_valid) | (|rsp_valid_q);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters: port 0 is the integer issue path and port 1 is the address/branch-compare helper path.
- Each port has a valid/ready request channel and a registered valid/ready response channel.
- Arbitration is round-robin, with one result buffer per port.
- Sits between the decode/issue stage and the single shared ALU.

Parameters:
- XLEN, 32, datapath width; passed to the internal alu.
- FAIR_RESET_PRI, 0, port that holds priority after reset (0 or 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid; bit i belongs to port i
- req_ready  out  2  per-port request accept
- req_a  in  2*XLEN  operand d0; port i is in slice [i*XLEN +: XLEN]
- req_b  in  2*XLEN  operand d1
- req_op  in  8  4-bit ALU select per port (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9)
- req_word  in  2  per-port is_word_op
- rsp_valid  out  2  per-port result valid
- rsp_ready  in  2  per-port result consume
- rsp_data  out  2*XLEN  per-port registered result
- busy  out  1  high when any request is pending or any result buffer is full

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, priority pointer=FAIR_RESET_PRI. Reset overrides any in-flight handshake, and buffered results are discarded.
- Buffer state per port: EMPTY or FULL, tracked by rsp_valid[i].
- can_accept[i] = !rsp_valid[i] || rsp_ready[i]. A result may be drained and replaced in the same cycle.
- Eligibility: eligible[i] = req_valid[i] && can_accept[i].
- Grant: at most one port per cycle.
  - If exactly one port is eligible, it wins.
  - If both are eligible, the port named by the priority pointer wins.
- req_ready[i] = grant[i]. It is combinational from req_valid, rsp_valid, rsp_ready and the pointer.
- There is no combinational path from req_a, req_b or req_op to req_ready.
- Datapath: the mux drives the granted port's a, b, op and word into the alu. When there is no grant, the mux drives port 0 fields and the result is ignored.
- Latency: exactly 1 cycle. A result accepted in cycle N has rsp_valid high and rsp_data valid from cycle N+1.
- Result capture: on grant[i], rsp_data[i] <= alu.y and rsp_valid[i] <= 1.
- Drain: if rsp_valid[i] && rsp_ready[i] && !grant[i], then rsp_valid[i] <= 0.
- Drain plus grant in the same cycle: rsp_valid[i] stays 1 and rsp_data[i] takes the new value (back-to-back throughput of 1 per cycle per port).
- Stall: while rsp_valid[i]=1 and rsp_ready[i]=0, rsp_data[i] is held stable and port i is not granted. The other port may still be granted.
- Pointer update: only on a cycle where both ports are eligible, the pointer moves to the non-winner. A single-eligible grant leaves the pointer unchanged.
- Fairness bound: a continuously eligible port is granted within 2 cycles.
- Request-side rule: a requester holds req_* stable while req_valid=1 and req_ready=0. The block does not check this.
- Undefined op codes (10..15): the alu yields 0. The block accepts and returns 0 normally.
- Word ops: the alu sign-extends from bit 31. When XLEN=32 the result is the low 32 bits unchanged.
- busy = |req_valid | |rsp_valid.

Test Plan:
- Single op: reset, then port0 ADD a=5 b=7 with rsp_ready=1. Expect req_ready[0]=1 in cycle 1, then rsp_valid[0]=1 and rsp_data[0]=12 in cycle 2, then rsp_valid[0]=0 in cycle 3.
- Contention:
  - Stimulus: both ports valid every cycle, all rsp_ready=1.
  - Port0 issues SUB 3-5; port1 issues SLTU a=1 b=0xFFFFFFFF.
  - Expect grants to alternate 0,1,0,1 starting with port FAIR_RESET_PRI.
  - Expect port0 results 0xFFFFFFFE and port1 results 1.
- Backpressure:
  - Stimulus: port0 result buffered with rsp_ready[0]=0 held for 4 cycles; port0 keeps req_valid=1; port1 issues SRA 0x80000000 by 4.
  - Expect rsp_data[0] stable, req_ready[0]=0 throughout, and port1 granted every cycle with result 0xF8000000.
- Drain-and-refill: port0 sends consecutive ORs with rsp_ready[0]=1 every cycle. Expect one result per cycle, rsp_valid[0] continuously 1 and data in order.
- Reset mid-operation: assert reset while rsp_valid=2'b11. Next cycle expect rsp_valid=0, rsp_data=0, busy=0 and pointer=FAIR_RESET_PRI.
- Shift masking (XLEN=32): port1 SLL a=1 b=33 with word=0. Expect rsp_data=2, since only the low shift-amount bits are used.
